// File: rtl/score_event_conditioner.sv
// Score-line conditioner: synchronizes, debounces and edge-detects the raw Arduino score line,
// gates it with game_active and applies a re-trigger lockout before emitting a one-cycle pulse.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ARMED   | waiting for a debounced rising edge; accepts it if game_active
//   LOCKOUT | counting out the re-trigger window; rising edges are rejected
module score_event_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LOCKOUT_CYCLES  = 50_000_000,
   parameter int REJ_W           = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             raw_in,
   input  logic             game_active,
   output logic             score_pulse,
   output logic             stable_level,
   output logic             busy,
   output logic [REJ_W-1:0] rejected_count
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

   typedef enum logic {
      ARMED   = 1'b0,
      LOCKOUT = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic              s1, s2;
   logic [DEB_W-1:0]  deb_cnt;
   logic [LOCK_W-1:0] lock_cnt, lock_nxt;
   logic              pulse_nxt;
   logic              rej_inc;
   logic              rise;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw_in;
         s2 <= s1;
      end
   end

   // Any cycle where s2 agrees with the debounced level restarts the count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         deb_cnt      <= '0;
         stable_level <= 1'b0;
      end else if (s2 == stable_level) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
         deb_cnt      <= '0;
         stable_level <= s2;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   // Asserted in the cycle before the edge at which stable_level goes 0->1.
   assign rise = !stable_level && s2 && (deb_cnt == DEB_LAST);

   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_cnt;
      pulse_nxt = 1'b0;
      rej_inc   = 1'b0;
      case (state)
         ARMED: begin
            if (rise) begin
               if (game_active) begin
                  pulse_nxt = 1'b1;
                  lock_nxt  = '0;
                  state_nxt = LOCKOUT;
               end else begin
                  rej_inc = 1'b1;
               end
            end
         end
         LOCKOUT: begin
            rej_inc = rise;
            if (lock_cnt == LOCK_LAST) begin
               lock_nxt  = '0;
               state_nxt = ARMED;
            end else begin
               lock_nxt = lock_cnt + 1'b1;
            end
         end
         default: state_nxt = ARMED;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= ARMED;
         lock_cnt       <= '0;
         score_pulse    <= 1'b0;
         rejected_count <= '0;
      end else begin
         state       <= state_nxt;
         lock_cnt    <= lock_nxt;
         score_pulse <= pulse_nxt;
         if (rej_inc && (rejected_count != {REJ_W{1'b1}}))
            rejected_count <= rejected_count + 1'b1;
      end
   end

   assign busy = (state == LOCKOUT);

endmodule
